pb_gesture_decoder: RTL and testbench



---
 rtl/pb_gesture_decoder.sv | 147 ++++++++++++++
 tb/tb_pb_gesture_decoder.sv | 107 ++++++++++
 2 files changed

// File: rtl/pb_gesture_decoder.sv
// Push-button gesture classifier: short press, long press with auto-repeat, double click.
// Consumes the debouncer's level/press/release signals; all outputs registered.
module pb_gesture_decoder #(
    parameter int CNT_W         = 16,
    parameter int LONG_CYCLES   = 20,
    parameter int GAP_CYCLES    = 10,
    parameter int REPEAT_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       PB_pressed_status,
    input  logic       PB_pressed_pulse,
    input  logic       PB_released_pulse,
    output logic       short_press_pulse,
    output logic       long_press_pulse,
    output logic       hold_repeat_pulse,
    output logic       double_click_pulse,
    output logic [1:0] last_gesture
);

    // state    | meaning
    // IDLE     | no gesture in progress
    // PRESS1   | first press held, timing towards long press
    // HOLD     | long press held, emitting auto-repeat
    // WAIT_GAP | first press released, waiting for a second press
    // WAIT_REL | second press of a double click, waiting for release
    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS1,
        S_HOLD,
        S_WAIT_GAP,
        S_WAIT_REL
    } state_t;

    localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_TC    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

    localparam logic [1:0] G_SHORT  = 2'd1;
    localparam logic [1:0] G_LONG   = 2'd2;
    localparam logic [1:0] G_DOUBLE = 2'd3;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             double_q, double_d;
    logic [1:0]       last_q, last_d;
    logic             press, release_ev;

    // Press and release in the same cycle is a protocol violation: drop both.
    assign press      = PB_pressed_pulse & ~PB_released_pulse;
    assign release_ev = PB_released_pulse & ~PB_pressed_pulse;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        short_d  = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;
        double_d = 1'b0;
        last_d   = last_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (press) begin
                    state_d = S_PRESS1;
                end
            end
            S_PRESS1: begin
                if (release_ev) begin
                    state_d = S_WAIT_GAP;
                    cnt_d   = '0;
                end else if (!PB_pressed_status) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_TC) begin
                    long_d  = 1'b1;
                    last_d  = G_LONG;
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end
            end
            S_HOLD: begin
                if (release_ev || !PB_pressed_status) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == REPEAT_TC) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end
            end
            S_WAIT_GAP: begin
                if (press) begin
                    double_d = 1'b1;
                    last_d   = G_DOUBLE;
                    state_d  = S_WAIT_REL;
                    cnt_d    = '0;
                end else if (cnt_q == GAP_TC) begin
                    short_d = 1'b1;
                    last_d  = G_SHORT;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            S_WAIT_REL: begin
                cnt_d = '0;
                if (release_ev || !PB_pressed_status) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            double_q <= 1'b0;
            last_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            short_q  <= short_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
            double_q <= double_d;
            last_q   <= last_d;
        end
    end

    assign short_press_pulse  = short_q;
    assign long_press_pulse   = long_q;
    assign hold_repeat_pulse  = repeat_q;
    assign double_click_pulse = double_q;
    assign last_gesture       = last_q;

endmodule

// File: tb/tb_pb_gesture_decoder.sv
// Directed bench for pb_gesture_decoder: per-cycle checks of all outputs against
// hand-derived event edges (k = cycles after the edge that samples the first press).
module tb_pb_gesture_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       st, pp, rp;
    logic       short_p, long_p, rep_p, dbl_p;
    logic [1:0] last_g;

    int vectors     = 0;
    int miscompares = 0;

    pb_gesture_decoder #(
        .CNT_W        (16),
        .LONG_CYCLES  (20),
        .GAP_CYCLES   (10),
        .REPEAT_CYCLES(8)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .PB_pressed_status (st),
        .PB_pressed_pulse  (pp),
        .PB_released_pulse (rp),
        .short_press_pulse (short_p),
        .long_press_pulse  (long_p),
        .hold_repeat_pulse (rep_p),
        .double_click_pulse(dbl_p),
        .last_gesture      (last_g)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // expected vector: {short, long, repeat, double, last_gesture[1:0]}
    task automatic chk(input string tag, input int k, input logic [5:0] exp_v);
        logic [5:0] got;
        got = {short_p, long_p, rep_p, dbl_p, last_g};
        vectors++;
        assert (got === exp_v) else begin
            miscompares++;
            $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, got, exp_v);
        end
    endtask

    // One gesture: press pulse at k=0; -1 means "never" for any edge index.
    task automatic scen(input string tag,
                        input int rel1, input int st1_end,
                        input int press2, input int rel2,
                        input int rst_k, input int n,
                        input int k_s, input int k_l, input int k_r1, input int k_r2,
                        input int k_d,
                        input logic [1:0] last0, input int k_last, input logic [1:0] last1);
        logic [1:0] lexp;
        for (int i = 0; i < 3; i++) begin
            rst = 1'b0; st = 1'b0; pp = 1'b0; rp = 1'b0;
            cyc();
            chk({tag, "_idle"}, i, {4'b0000, last0});
        end
        for (int k = 0; k <= n; k++) begin
            rst = (k == rst_k);
            pp  = (k == 0) || (k == press2);
            rp  = (k == rel1) || (k == rel2);
            st  = (k < st1_end) || (press2 >= 0 && k >= press2 && k < rel2);
            cyc();
            lexp = last0;
            if (k_last >= 0 && k >= k_last) lexp = last1;
            if (rst_k >= 0 && k >= rst_k) lexp = 2'd0;
            chk(tag, k, {(k == k_s), (k == k_l), ((k == k_r1) || (k == k_r2)), (k == k_d), lexp});
        end
        rst = 1'b0; st = 1'b0; pp = 1'b0; rp = 1'b0;
    endtask

    initial begin
        rst = 1'b1; st = 1'b0; pp = 1'b0; rp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            st = 1'($urandom_range(1));
            pp = 1'($urandom_range(1));
            rp = 1'($urandom_range(1));
            cyc();
            chk("reset", i, 6'b000000);
        end
        rst = 1'b0; st = 1'b0; pp = 1'b0; rp = 1'b0;
        cyc();
        chk("reset_exit", 3, 6'b000000);

        //   tag            rel1 st1e p2  r2  rstk  n   short long r1  r2  dbl  last0 klast last1
        scen("short",         5,   5, -1, -1, -1, 20,  15,  -1, -1, -1, -1, 2'd0, 15, 2'd1);
        scen("long_repeat",  40,  40, -1, -1, -1, 50,  -1,  20, 28, 36, -1, 2'd1, 20, 2'd2);
        scen("double",        3,   3, 12, 15, -1, 30,  -1,  -1, -1, -1, 12, 2'd2, 12, 2'd3);
        scen("double_tc",     3,   3, 13, 16, -1, 30,  -1,  -1, -1, -1, 13, 2'd3, 13, 2'd3);
        scen("rel_at_19",    19,  19, -1, -1, -1, 35,  29,  -1, -1, -1, -1, 2'd3, 29, 2'd1);
        scen("rel_long_tie", 20,  20, -1, -1, -1, 35,  30,  -1, -1, -1, -1, 2'd1, 30, 2'd1);
        scen("both_pulses",   0,  25, -1, -1, -1, 30,  -1,  -1, -1, -1, -1, 2'd1, -1, 2'd1);
        scen("rst_in_hold",  40,  40, -1, -1, 25, 50,  -1,  20, -1, -1, -1, 2'd1, 20, 2'd2);
        scen("resync",       -1,   5, -1, -1, -1, 30,  -1,  -1, -1, -1, -1, 2'd0, -1, 2'd0);
        scen("short_after",   2,   2, -1, -1, -1, 15,  12,  -1, -1, -1, -1, 2'd0, 12, 2'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
